// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: owns the PC and walks one instruction at a time through
// FETCH/DECODE/REG/EX/MEM/WB/BR/JU using per-unit en/done handshakes. The phase
// path is chosen by the decoder's path_index, latched when DECODE completes.
// Optional per-phase watchdog: define MULTICYCLE_SEQ_WATCHDOG_EN.
module multicycle_sequencer #(
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned     PC_STEP  = 4,
  parameter int unsigned     PATH_W   = 4,
  parameter int unsigned     WDOG_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              top_en,
  input  logic              if_done,
  input  logic              id_done,
  input  logic              reg_done,
  input  logic              alu_done,
  input  logic              mem_done,
  input  logic              br_done,
  input  logic              ju_done,
  input  logic [PATH_W-1:0] path_index,
  input  logic [PC_W-1:0]   br_pc,
  input  logic [PC_W-1:0]   ju_pc,
  output logic              if_en,
  output logic              id_en,
  output logic              reg_en,
  output logic              alu_en,
  output logic              mem_en,
  output logic              br_en,
  output logic              ju_en,
  output logic              mem_wen,
  output logic              wb_en,
  output logic [PC_W-1:0]   pc,
  output logic [9:0]        phase,
  output logic              retire,
  output logic              halted,
  output logic              illegal,
  output logic              timeout
);

  // Enum order matches the one-hot phase bit positions.
  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_IF, S_ID, S_REG, S_EX, S_MEM, S_WB, S_BR, S_JU, S_HALT
  } state_e;

  localparam logic [PATH_W-1:0] PATH_ALU    = PATH_W'(0);
  localparam logic [PATH_W-1:0] PATH_LOAD   = PATH_W'(1);
  localparam logic [PATH_W-1:0] PATH_STORE  = PATH_W'(2);
  localparam logic [PATH_W-1:0] PATH_BRANCH = PATH_W'(3);
  localparam logic [PATH_W-1:0] PATH_JUMP   = PATH_W'(4);
  localparam logic [PATH_W-1:0] PATH_JR     = PATH_W'(5);
  localparam logic [PATH_W-1:0] PATH_HALT   = PATH_W'(6);

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [PATH_W-1:0]   path_q, path_d;
  logic                retire_q, retire_d;
  logic                halted_q, halted_d;
  logic                illegal_q, illegal_d;
  logic                complete;
  logic [PC_W-1:0]     target_pc;

`ifdef MULTICYCLE_SEQ_WATCHDOG_EN
  localparam logic [WDOG_W-1:0] WD_LAST = {{(WDOG_W-1){1'b1}}, 1'b0};
  logic [WDOG_W-1:0] wd_cnt_q, wd_cnt_d;
  logic              timeout_q, timeout_d;
  logic              wd_wait;

  // Waiting means: in a handshake phase whose unit has not signalled done.
  always_comb begin
    unique case (state_q)
      S_IF:    wd_wait = !if_done;
      S_ID:    wd_wait = !id_done;
      S_REG:   wd_wait = !reg_done;
      S_EX:    wd_wait = !alu_done;
      S_MEM:   wd_wait = !mem_done;
      S_BR:    wd_wait = !br_done;
      S_JU:    wd_wait = !ju_done;
      default: wd_wait = 1'b0;
    endcase
  end
`endif

  // Next-state, PC and flag logic; completion is folded into one block at the end.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    path_d    = path_q;
    retire_d  = 1'b0;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    complete  = 1'b0;
    target_pc = pc_q + PC_W'(PC_STEP);
    unique case (state_q)
      S_IDLE: if (top_en) state_d = S_IF;
      S_IF:   if (if_done) state_d = S_ID;
      S_ID: begin
        if (id_done) begin
          path_d = path_index;
          case (path_index)
            PATH_ALU, PATH_LOAD, PATH_STORE, PATH_BRANCH, PATH_JR: state_d = S_REG;
            PATH_JUMP: state_d = S_JU;
            PATH_HALT: begin
              state_d  = S_HALT;
              halted_d = 1'b1;
            end
            default: begin
              illegal_d = 1'b1;
              complete  = 1'b1;
            end
          endcase
        end
      end
      S_REG: if (reg_done) state_d = (path_q == PATH_JR) ? S_JU : S_EX;
      S_EX: begin
        if (alu_done) begin
          if (path_q == PATH_LOAD || path_q == PATH_STORE) state_d = S_MEM;
          else if (path_q == PATH_BRANCH)                  state_d = S_BR;
          else                                             state_d = S_WB;
        end
      end
      S_MEM: begin
        if (mem_done) begin
          if (path_q == PATH_LOAD) state_d = S_WB;
          else                     complete = 1'b1;
        end
      end
      S_WB: complete = 1'b1;
      S_BR: begin
        if (br_done) begin
          complete  = 1'b1;
          target_pc = br_pc;
        end
      end
      S_JU: begin
        if (ju_done) begin
          complete  = 1'b1;
          target_pc = ju_pc;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
    if (complete) begin
      pc_d     = target_pc;
      retire_d = 1'b1;
      state_d  = top_en ? S_IF : S_IDLE;
    end
`ifdef MULTICYCLE_SEQ_WATCHDOG_EN
    wd_cnt_d  = '0;
    timeout_d = timeout_q;
    if (wd_wait) begin
      if (wd_cnt_q == WD_LAST) begin
        timeout_d = 1'b1;
        halted_d  = 1'b1;
        state_d   = S_HALT;
      end else begin
        wd_cnt_d = wd_cnt_q + 1'b1;
      end
    end
`endif
  end

  // State, PC and sticky flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      path_q    <= '0;
      retire_q  <= 1'b0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      path_q    <= path_d;
      retire_q  <= retire_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
    end
  end

`ifdef MULTICYCLE_SEQ_WATCHDOG_EN
  // Watchdog counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
    end
  end
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign if_en   = (state_q == S_IF);
  assign id_en   = (state_q == S_ID);
  assign reg_en  = (state_q == S_REG);
  assign alu_en  = (state_q == S_EX);
  assign mem_en  = (state_q == S_IF) || (state_q == S_MEM);
  assign mem_wen = (state_q == S_MEM) && (path_q == PATH_STORE);
  assign br_en   = (state_q == S_BR);
  assign ju_en   = (state_q == S_JU);
  assign wb_en   = (state_q == S_WB);
  assign pc      = pc_q;
  assign phase   = 10'b1 << state_q;
  assign retire  = retire_q;
  assign halted  = halted_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer (default build, watchdog off).
// A path table gives each instruction's phase list; the bench drives each unit's
// done after a random delay and compares every cycle's outputs to that model.
module tb_multicycle_sequencer;

  localparam int P_IDLE = 0, P_IF = 1, P_ID = 2, P_REG = 3, P_EX = 4;
  localparam int P_MEM = 5, P_WB = 6, P_BR = 7, P_JU = 8, P_HALT = 9;

  logic        clk = 1'b0;
  logic        rst, top_en;
  logic        if_done, id_done, reg_done, alu_done, mem_done, br_done, ju_done;
  logic [3:0]  path_index;
  logic [31:0] br_pc, ju_pc;
  logic        if_en, id_en, reg_en, alu_en, mem_en, br_en, ju_en, mem_wen, wb_en;
  logic [31:0] pc;
  logic [9:0]  phase;
  logic        retire, halted, illegal, timeout;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_pc;
  bit          exp_ill, exp_halt, ret_now;
  logic [54:0] obs, expv;

  always #5 clk = ~clk;

  multicycle_sequencer #(
    .PC_W(32), .RESET_PC(32'h0), .PC_STEP(4), .PATH_W(4), .WDOG_W(8)
  ) dut (
    .clk(clk), .rst(rst), .top_en(top_en),
    .if_done(if_done), .id_done(id_done), .reg_done(reg_done), .alu_done(alu_done),
    .mem_done(mem_done), .br_done(br_done), .ju_done(ju_done),
    .path_index(path_index), .br_pc(br_pc), .ju_pc(ju_pc),
    .if_en(if_en), .id_en(id_en), .reg_en(reg_en), .alu_en(alu_en), .mem_en(mem_en),
    .br_en(br_en), .ju_en(ju_en), .mem_wen(mem_wen), .wb_en(wb_en),
    .pc(pc), .phase(phase), .retire(retire), .halted(halted), .illegal(illegal),
    .timeout(timeout)
  );

  assign obs = {phase, if_en, id_en, reg_en, alu_en, mem_en, mem_wen, wb_en, br_en, ju_en,
                retire, halted, illegal, timeout, pc};

  // Expected outputs while sitting in phase p of an instruction of class path.
  function automatic logic [54:0] model(int p, int path, bit ret, logic [31:0] pcv,
                                        bit h, bit il);
    logic [9:0] ph;
    ph = 10'b1 << p;
    return {ph, p == P_IF, p == P_ID, p == P_REG, p == P_EX, (p == P_IF || p == P_MEM),
            (p == P_MEM && path == 2), p == P_WB, p == P_BR, p == P_JU,
            ret, h, il, 1'b0, pcv};
  endfunction

  task automatic drive_noise();
    {if_done, id_done, reg_done, alu_done, mem_done, br_done, ju_done} = 7'($urandom);
    path_index = 4'($urandom);
    br_pc      = $urandom;
    ju_pc      = $urandom;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    top_en = 1'b0;
    drive_noise();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_pc = 32'h0; exp_ill = 1'b0; exp_halt = 1'b0; ret_now = 1'b0;
  endtask

  task automatic start_fetch();
    top_en = 1'b1;
    drive_noise();
    @(negedge clk);
    ret_now = 1'b0;
  endtask

  // Runs one instruction starting at a negedge in FETCH; ends at the negedge after completion.
  task automatic run_instr(input int path, input int max_dly, input int mem_dly,
                           input logic [31:0] tgt, input bit en_after, output int cycles);
    int ph[$];
    int drop_i;
    logic [31:0] nxt;
    ph = {P_IF, P_ID};
    case (path)
      0: ph = {ph, P_REG, P_EX, P_WB};
      1: ph = {ph, P_REG, P_EX, P_MEM, P_WB};
      2: ph = {ph, P_REG, P_EX, P_MEM};
      3: ph = {ph, P_REG, P_EX, P_BR};
      4: ph.push_back(P_JU);
      5: ph = {ph, P_REG, P_JU};
      default: ;
    endcase
    nxt = (path >= 3 && path <= 5) ? tgt : exp_pc + 32'd4;
    drop_i = ph.size() - 1;
    foreach (ph[i]) if (ph[i] == P_EX) drop_i = i;
    cycles = 0;
    for (int i = 0; i < ph.size(); i++) begin
      int p, d;
      p = ph[i];
      if (p == P_WB) d = 0;
      else if (p == P_MEM && mem_dly >= 0) d = mem_dly;
      else d = $urandom_range(0, max_dly);
      for (int k = 0; k <= d; k++) begin
        expv = model(p, path, ret_now, exp_pc, 1'b0, exp_ill);
        checks++;
        if (obs !== expv) begin
          errors++;
          $display("FAIL cycle path=%0d phase_bit=%0d got %h expected %h", path, p, obs, expv);
        end
        cycles++;
        drive_noise();
        case (p)
          P_IF:  if_done  = (k == d);
          P_ID:  id_done  = (k == d);
          P_REG: reg_done = (k == d);
          P_EX:  alu_done = (k == d);
          P_MEM: mem_done = (k == d);
          P_BR:  br_done  = (k == d);
          P_JU:  ju_done  = (k == d);
          default: ;
        endcase
        if (p == P_ID && k == d) path_index = 4'(path);
        if (p == P_BR && k == d) br_pc = tgt;
        if (p == P_JU && k == d) ju_pc = tgt;
        if (i == drop_i && k == 0) top_en = en_after;
        @(negedge clk);
        ret_now = 1'b0;
      end
    end
    exp_pc = nxt;
    if (path > 6) exp_ill = 1'b1;
    ret_now = 1'b1;
    expv = model(en_after ? P_IF : P_IDLE, path, 1'b1, exp_pc, 1'b0, exp_ill);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL completion path=%0d got %h expected %h", path, obs, expv);
    end
  endtask

  task automatic test_reset();
    do_reset();
    for (int n = 0; n < 2; n++) begin
      expv = model(P_IDLE, 0, 1'b0, 32'h0, 1'b0, 1'b0);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL reset_state got %h expected %h", obs, expv);
      end
      drive_noise();
      @(negedge clk);
    end
  endtask

  task automatic test_alu_basic();
    int c;
    run_instr(0, 0, -1, 32'h0, 1'b1, c);
    checks++;
    if (c !== 5) begin
      errors++;
      $display("FAIL alu_latency got %0d expected 5", c);
    end
  endtask

  task automatic test_load_delay();
    int c;
    run_instr(1, 0, 3, 32'h0, 1'b1, c);
    checks++;
    if (c !== 9) begin
      errors++;
      $display("FAIL load_latency got %0d expected 9", c);
    end
    run_instr(2, 2, 2, 32'h0, 1'b1, c);
  endtask

  task automatic test_branch_jump();
    int c;
    run_instr(3, 1, -1, 32'h40, 1'b1, c);
    run_instr(4, 1, -1, 32'h100, 1'b1, c);
    run_instr(5, 1, -1, 32'h1234, 1'b1, c);
  endtask

  task automatic test_wrap();
    int c;
    run_instr(4, 0, -1, 32'hFFFF_FFFC, 1'b1, c);
    run_instr(9, 0, -1, 32'h0, 1'b1, c);
  endtask

  task automatic test_random();
    int c, r, path;
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 7);
      path = (r < 6) ? r : $urandom_range(7, 15);
      run_instr(path, 3, -1, $urandom, 1'b1, c);
    end
  endtask

  task automatic test_top_en_drop();
    int c;
    run_instr(0, 2, -1, 32'h0, 1'b0, c);
    for (int n = 0; n < 3; n++) begin
      expv = model(P_IDLE, 0, ret_now, exp_pc, 1'b0, exp_ill);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL idle_after_drop got %h expected %h", obs, expv);
      end
      drive_noise();
      @(negedge clk);
      ret_now = 1'b0;
    end
    start_fetch();
    run_instr(1, 1, -1, 32'h0, 1'b1, c);
  endtask

  task automatic test_reset_mid();
    int c;
    run_instr(4, 0, -1, 32'h200, 1'b1, c);
    {if_done, id_done, reg_done, alu_done, mem_done, br_done, ju_done} = 7'b1111011;
    path_index = 4'd1;
    repeat (4) @(negedge clk);
    ret_now = 1'b0;
    expv = model(P_MEM, 1, 1'b0, 32'h200, 1'b0, exp_ill);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL pre_reset_mem got %h expected %h", obs, expv);
    end
    rst = 1'b1;
    @(negedge clk);
    expv = model(P_IDLE, 0, 1'b0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL reset_mid_mem got %h expected %h", obs, expv);
    end
    do_reset();
    start_fetch();
  endtask

  task automatic test_halt();
    int c;
    run_instr(0, 0, -1, 32'h0, 1'b1, c);
    for (int s = 0; s < 2; s++) begin
      expv = model(s == 0 ? P_IF : P_ID, 6, ret_now, exp_pc, 1'b0, exp_ill);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL halt_lead got %h expected %h", obs, expv);
      end
      drive_noise();
      if (s == 0) if_done = 1'b1;
      else begin
        id_done = 1'b1;
        path_index = 4'd6;
      end
      @(negedge clk);
      ret_now = 1'b0;
    end
    exp_halt = 1'b1;
    for (int n = 0; n < 6; n++) begin
      expv = model(P_HALT, 6, 1'b0, exp_pc, exp_halt, exp_ill);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL halt_hold got %h expected %h", obs, expv);
      end
      drive_noise();
      top_en = 1'($urandom);
      @(negedge clk);
    end
    do_reset();
    expv = model(P_IDLE, 0, 1'b0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL halt_cleared got %h expected %h", obs, expv);
    end
  endtask

  initial begin
    rst = 1'b1;
    top_en = 1'b0;
    drive_noise();
    @(negedge clk);
    test_reset();
    start_fetch();
    test_alu_basic();
    test_load_delay();
    test_branch_jump();
    test_wrap();
    test_random();
    test_top_en_drop();
    test_reset_mid();
    test_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
